uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` requesters. It latches the winning requester's byte and parity settings, then issues a single-cycle load strobe to the transmitter. It tracks the transmitter's `busy` to detect frame completion, acknowledges the requester and enforces an inter-frame gap. It sits between client blocks and the UART TX top, driving its `P_DATA`, `Data_Valid`, `PAR_EN` and `PAR_TYP` inputs.

---
 rtl/uart_sched_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/uart_tx_scheduler.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler.
// Contents:
//   ST_*     - FSM state encodings (3-bit, legacy-compatible constants)
//   data_w   - frame data width from the DATAWIDTH exponent
//   cnt_w    - counter width able to hold 0..maxv (never less than 1 bit)
package uart_sched_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;

  function automatic int data_w(input int dw);
    return 1 << dw;
  endfunction

  function automatic int cnt_w(input int maxv);
    return (maxv < 1) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick for the UART transmit scheduler.
// Ports:
//   req_i   - request vector, one bit per requester
//   ptr_i   - round-robin pointer: search starts at this index
//   grant_o - one-hot winner (all zero when no request)
//   idx_o   - binary index of the winner
//   valid_o - at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] src;
  logic               found;

  // Requests at or above the pointer take priority; if none of those are
  // set, the search wraps and the lowest set bit overall wins.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (i >= int'(ptr_i));
    end
    masked = req_i & mask;
    src    = (|masked) ? masked : req_i;

    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src[i] && !found) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = PTR_W'(i);
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ clients.
// Ports:
//   CLK, RST_ASYN        - clock (rising edge), async active-low reset
//   REQ, REQ_DATA        - per-requester request level and byte lanes
//   REQ_PAR_EN/_TYP      - per-requester parity settings
//   TX_BUSY              - transmitter busy flag
//   TX_P_DATA, TX_DATA_VALID, TX_PAR_EN, TX_PAR_TYP - transmitter load side
//   GRANT                - one-hot owner of the frame in flight
//   ACK                  - one-cycle completion pulse on the owner's bit
//   ERR                  - one-cycle pulse when TX_BUSY never rose
//   SCHED_BUSY           - high whenever the FSM is not idle
// All outputs come straight from registers.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int DATAWIDTH    = 3,
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                                   CLK,
  input  logic                                   RST_ASYN,
  input  logic [NUM_REQ-1:0]                     REQ,
  input  logic [NUM_REQ*data_w(DATAWIDTH)-1:0]   REQ_DATA,
  input  logic [NUM_REQ-1:0]                     REQ_PAR_EN,
  input  logic [NUM_REQ-1:0]                     REQ_PAR_TYP,
  input  logic                                   TX_BUSY,
  output logic [data_w(DATAWIDTH)-1:0]           TX_P_DATA,
  output logic                                   TX_DATA_VALID,
  output logic                                   TX_PAR_EN,
  output logic                                   TX_PAR_TYP,
  output logic [NUM_REQ-1:0]                     GRANT,
  output logic [NUM_REQ-1:0]                     ACK,
  output logic                                   ERR,
  output logic                                   SCHED_BUSY
);

  localparam int W     = data_w(DATAWIDTH);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (cnt_w(BUSY_TIMEOUT) > cnt_w(GAP_CYCLES)) ?
                         cnt_w(BUSY_TIMEOUT) : cnt_w(GAP_CYCLES);
  // With no gap configured, a finished frame returns straight to IDLE.
  localparam logic [2:0] ST_AFTER = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  logic [2:0]         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       data_q, data_d;
  logic               par_en_q, par_en_d;
  logic               par_typ_q, par_typ_d;
  logic               valid_q, valid_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_i   (REQ),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    grant_d   = grant_q;
    valid_d   = 1'b0;
    ack_d     = '0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Capture happens here so the strobe is already high in LOAD.
        if (arb_valid) begin
          data_d    = REQ_DATA[arb_idx*W +: W];
          par_en_d  = REQ_PAR_EN[arb_idx];
          par_typ_d = REQ_PAR_TYP[arb_idx];
          grant_d   = arb_grant;
          valid_d   = 1'b1;
          ptr_d     = (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + PTR_W'(1);
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (TX_BUSY) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          // This cycle would bring the count to BUSY_TIMEOUT: give up.
          err_d   = 1'b1;
          grant_d = '0;
          cnt_d   = '0;
          state_d = ST_AFTER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!TX_BUSY) begin
          ack_d   = grant_q;
          grant_d = '0;
          cnt_d   = '0;
          state_d = ST_AFTER;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_ASYN) begin
    if (!RST_ASYN) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      valid_q   <= 1'b0;
      grant_q   <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      valid_q   <= valid_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_P_DATA     = data_q;
  assign TX_DATA_VALID = valid_q;
  assign TX_PAR_EN     = par_en_q;
  assign TX_PAR_TYP    = par_typ_q;
  assign GRANT         = grant_q;
  assign ACK           = ack_q;
  assign ERR           = err_q;
  assign SCHED_BUSY    = busy_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: one default build (gap 2, timeout 4)
// and one build with GAP_CYCLES=0 sharing the clock and reset.
module tb_uart_tx_scheduler;

  logic        CLK;
  logic        RST_ASYN;

  // Default build
  logic [3:0]  req_a, paren_a, partyp_a;
  logic [31:0] rdata_a;
  logic        busy_a;
  logic [7:0]  txd_a;
  logic        vld_a, pen_a, ptyp_a, err_a, sbusy_a;
  logic [3:0]  gnt_a, ack_a;

  // GAP_CYCLES=0 build
  logic [3:0]  req_b, paren_b, partyp_b;
  logic [31:0] rdata_b;
  logic        busy_b;
  logic [7:0]  txd_b;
  logic        vld_b, pen_b, ptyp_b, err_b, sbusy_b;
  logic [3:0]  gnt_b, ack_b;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_scheduler #(.DATAWIDTH(3), .NUM_REQ(4), .GAP_CYCLES(2), .BUSY_TIMEOUT(4)) dut_a (
    .CLK(CLK), .RST_ASYN(RST_ASYN), .REQ(req_a), .REQ_DATA(rdata_a),
    .REQ_PAR_EN(paren_a), .REQ_PAR_TYP(partyp_a), .TX_BUSY(busy_a),
    .TX_P_DATA(txd_a), .TX_DATA_VALID(vld_a), .TX_PAR_EN(pen_a), .TX_PAR_TYP(ptyp_a),
    .GRANT(gnt_a), .ACK(ack_a), .ERR(err_a), .SCHED_BUSY(sbusy_a)
  );

  uart_tx_scheduler #(.DATAWIDTH(3), .NUM_REQ(4), .GAP_CYCLES(0), .BUSY_TIMEOUT(4)) dut_b (
    .CLK(CLK), .RST_ASYN(RST_ASYN), .REQ(req_b), .REQ_DATA(rdata_b),
    .REQ_PAR_EN(paren_b), .REQ_PAR_TYP(partyp_b), .TX_BUSY(busy_b),
    .TX_P_DATA(txd_b), .TX_DATA_VALID(vld_b), .TX_PAR_EN(pen_b), .TX_PAR_TYP(ptyp_b),
    .GRANT(gnt_b), .ACK(ack_b), .ERR(err_b), .SCHED_BUSY(sbusy_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_ASYN = 1'b0;
    tick();
    tick();
    RST_ASYN = 1'b1;
  endtask

  // Wait (bounded) for a strobe on the default build; n = edges waited.
  task automatic wait_strobe_a(output int n);
    n = 0;
    while (n < 12 && vld_a !== 1'b1) begin
      tick();
      n++;
    end
    check_eq("strobe_seen", {31'd0, vld_a}, 32'd1);
  endtask

  // Called in the LOAD cycle: hold busy for busy_len edges, then expect ACK.
  task automatic run_frame_a(input int busy_len, input logic [3:0] exp_ack);
    tick();
    check_eq("strobe_one_cycle", {31'd0, vld_a}, 32'd0);
    busy_a = 1'b1;
    repeat (busy_len) tick();
    busy_a = 1'b0;
    tick();
    check_eq("frame_ack", {28'd0, ack_a}, {28'd0, exp_ack});
    check_eq("grant_cleared", {28'd0, gnt_a}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    RST_ASYN = 1'b0;
    req_a = '0; paren_a = '0; partyp_a = '0; rdata_a = '0; busy_a = 1'b0;
    req_b = '0; paren_b = '0; partyp_b = '0; rdata_b = '0; busy_b = 1'b0;

    // Reset state
    tick();
    check_eq("rst_valid", {31'd0, vld_a}, 32'd0);
    check_eq("rst_grant", {28'd0, gnt_a}, 32'd0);
    check_eq("rst_ack",   {28'd0, ack_a}, 32'd0);
    check_eq("rst_err",   {31'd0, err_a}, 32'd0);
    check_eq("rst_sbusy", {31'd0, sbusy_a}, 32'd0);
    check_eq("rst_data",  {24'd0, txd_a}, 32'd0);
    RST_ASYN = 1'b1;
    tick();

    // Single requester 2: 0xA5, parity on, even
    req_a = 4'b0100; rdata_a = 32'h00A5_0000; paren_a = 4'b0100; partyp_a = 4'b0000;
    tick();
    check_eq("t1_strobe", {31'd0, vld_a}, 32'd1);
    check_eq("t1_data",   {24'd0, txd_a}, 32'hA5);
    check_eq("t1_grant",  {28'd0, gnt_a}, 32'b0100);
    check_eq("t1_paren",  {31'd0, pen_a}, 32'd1);
    check_eq("t1_partyp", {31'd0, ptyp_a}, 32'd0);
    check_eq("t1_sbusy",  {31'd0, sbusy_a}, 32'd1);
    run_frame_a(11, 4'b0100);
    req_a = '0;
    check_eq("t1_gap1_sbusy", {31'd0, sbusy_a}, 32'd1);
    tick();
    check_eq("t1_gap2_sbusy", {31'd0, sbusy_a}, 32'd1);
    check_eq("t1_ack_pulse",  {28'd0, ack_a}, 32'd0);
    tick();
    check_eq("t1_idle_sbusy", {31'd0, sbusy_a}, 32'd0);

    // All four requesting: order 0,1,2,3,0 from a reset pointer
    do_reset();
    req_a = 4'b1111; rdata_a = 32'h4433_2211; paren_a = '0; partyp_a = '0;
    for (int k = 0; k < 5; k++) begin
      wait_strobe_a(n);
      check_eq("rr_latency", n, (k == 0) ? 32'd1 : 32'd3);
      check_eq("rr_grant", {28'd0, gnt_a}, 32'd1 << (k % 4));
      check_eq("rr_data",  {24'd0, txd_a}, 32'h11 * ((k % 4) + 1));
      run_frame_a(3, 4'b0001 << (k % 4));
    end
    req_a = '0;
    repeat (3) tick();

    // Busy never rises: ERR 4 cycles after WAIT_BUSY entry
    do_reset();
    req_a = 4'b0010; rdata_a = 32'h0000_7700;
    tick();
    check_eq("to_strobe", {31'd0, vld_a}, 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("to_err_early", {31'd0, err_a}, 32'd0);
    end
    tick();
    check_eq("to_err",   {31'd0, err_a}, 32'd1);
    check_eq("to_noack", {28'd0, ack_a}, 32'd0);
    check_eq("to_grant", {28'd0, gnt_a}, 32'd0);
    req_a = 4'b0001; rdata_a = 32'h0000_0066;
    tick();
    check_eq("to_err_pulse", {31'd0, err_a}, 32'd0);
    n = 0;
    while (n < 12 && vld_a !== 1'b1) begin tick(); n++; end
    check_eq("to_next_lat",   n, 32'd2);
    check_eq("to_next_grant", {28'd0, gnt_a}, 32'b0001);
    check_eq("to_next_data",  {24'd0, txd_a}, 32'h66);
    run_frame_a(2, 4'b0001);
    req_a = '0;
    repeat (3) tick();

    // Owner drops REQ and changes data mid-frame
    do_reset();
    req_a = 4'b1000; rdata_a = 32'h5A00_0000; paren_a = 4'b1000; partyp_a = 4'b1000;
    tick();
    check_eq("md_data0",   {24'd0, txd_a}, 32'h5A);
    check_eq("md_partyp0", {31'd0, ptyp_a}, 32'd1);
    req_a = '0; rdata_a = 32'hFF00_0000; paren_a = '0; partyp_a = '0;
    tick();
    check_eq("md_data1", {24'd0, txd_a}, 32'h5A);
    busy_a = 1'b1;
    repeat (5) tick();
    check_eq("md_data2",  {24'd0, txd_a}, 32'h5A);
    check_eq("md_paren",  {31'd0, pen_a}, 32'd1);
    check_eq("md_grant",  {28'd0, gnt_a}, 32'b1000);
    busy_a = 1'b0;
    tick();
    check_eq("md_ack", {28'd0, ack_a}, 32'b1000);
    repeat (3) tick();

    // Reset during WAIT_DONE
    req_a = 4'b0010; rdata_a = 32'h0000_3C00;
    wait_strobe_a(n);
    tick();
    busy_a = 1'b1;
    tick();
    RST_ASYN = 1'b0;
    #1;
    check_eq("ar_grant", {28'd0, gnt_a}, 32'd0);
    check_eq("ar_sbusy", {31'd0, sbusy_a}, 32'd0);
    check_eq("ar_data",  {24'd0, txd_a}, 32'd0);
    busy_a = 1'b0;
    req_a = 4'b1001; rdata_a = 32'h9900_0081;
    tick();
    check_eq("ar_noack", {28'd0, ack_a}, 32'd0);
    check_eq("ar_noerr", {31'd0, err_a}, 32'd0);
    RST_ASYN = 1'b1;
    wait_strobe_a(n);
    check_eq("ar_first_grant", {28'd0, gnt_a}, 32'b0001);
    check_eq("ar_first_data",  {24'd0, txd_a}, 32'h81);
    run_frame_a(1, 4'b0001);
    req_a = '0;
    repeat (3) tick();

    // GAP_CYCLES=0 build: next strobe right after the ACK cycle
    req_b = 4'b0011; rdata_b = 32'h0000_3CC3;
    tick();
    check_eq("g0_strobe0", {31'd0, vld_b}, 32'd1);
    check_eq("g0_grant0",  {28'd0, gnt_b}, 32'b0001);
    tick();
    busy_b = 1'b1;
    repeat (2) tick();
    busy_b = 1'b0;
    tick();
    check_eq("g0_ack0",   {28'd0, ack_b}, 32'b0001);
    check_eq("g0_idle",   {31'd0, sbusy_b}, 32'd0);
    req_b = 4'b0010;
    tick();
    check_eq("g0_strobe1", {31'd0, vld_b}, 32'd1);
    check_eq("g0_grant1",  {28'd0, gnt_b}, 32'b0010);
    check_eq("g0_data1",   {24'd0, txd_b}, 32'h3C);
    tick();
    busy_b = 1'b1;
    tick();
    busy_b = 1'b0;
    tick();
    check_eq("g0_ack1", {28'd0, ack_b}, 32'b0010);
    req_b = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
